pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Takes register-use and rd info from the ID stage, redirect from EX, and the data-memory handshake from MEM.
- Drives stall, flush, bubble and freeze strobes to the pipeline registers.
- Keeps its own shadow scoreboard of in-flight EX/MEM destinations, a memory-wait FSM with timeout, and a fence.i drain FSM.

Parameters:
- FWD_EN, 1: 1 = EX/MEM bypass exists, only load-use stalls; 0 = any RAW against EX or MEM stalls.
- MEM_TIMEOUT, 16: total freeze cycles allowed for one memory access before forced release (>=2).
- CNT_W, 64: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_ena  in  1  ID reads rs1.
- id_rs1_addr  in  5  rs1 index.
- id_rs2_ena  in  1  ID reads rs2.
- id_rs2_addr  in  5  rs2 index.
- id_rd_ena  in  1  ID writes rd.
- id_rd_addr  in  5  rd index.
- id_mem_to_reg  in  1  ID instruction is a load.
- id_fence_i  in  1  ID instruction is fence.i.
- ex_redirect  in  1  EX resolved a taken branch/jal/jalr this cycle.
- mem_req  in  1  MEM stage has an outstanding data access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID register.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- pipe_freeze  out  1  hold all pipeline registers, including EX/MEM and MEM/WB.
- fence_i_pulse  out  1  one-cycle I-cache invalidate request.
- mem_timeout  out  1  one-cycle pulse; MEM treats it as access done with error.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1.

Behaviour:
- Reset (async, rst=1):
  - All shadow registers are 0.
  - Memory FSM is RUN, wait counter is 0, fence FSM is IDLE, stall_cycles is 0.
  - All combinational outputs are forced to 0 while rst=1.
- Shadow scoreboard: two stages, {ex_valid, ex_rd, ex_ld} and {mem_valid, mem_rd, mem_ld}. rd is stored only when id_rd_ena=1, otherwise 0.
  - On each non-frozen clock edge, the MEM shadow takes the EX shadow.
  - The EX shadow takes the ID fields when issue=1, else 0.
  - issue = id_valid & ~ifid_stall & ~ex_redirect.
  - While pipe_freeze=1, both shadows hold.
- Hazard detect: match(x) = x!=0 & ((id_rs1_ena & id_rs1_addr==x) | (id_rs2_ena & id_rs2_addr==x)).
  - FWD_EN=1: lu = id_valid & ex_valid & ex_ld & match(ex_rd).
  - FWD_EN=0: lu = id_valid & ((ex_valid & match(ex_rd)) | (mem_valid & match(mem_rd))).
- Memory FSM:
  - RUN: if mem_req & ~mem_ready, pipe_freeze=1 combinationally, counter<=1, go to MEM_WAIT.
  - MEM_WAIT, mem_ready=1: pipe_freeze=0, go to RUN, counter<=0.
  - MEM_WAIT, counter==MEM_TIMEOUT: pipe_freeze=0, mem_timeout=1, go to RUN, counter<=0.
  - MEM_WAIT, otherwise: pipe_freeze=1, counter++.
  - Total freeze is at most MEM_TIMEOUT cycles; the timeout pulse lands on cycle MEM_TIMEOUT+1.
- Fence FSM, entered when fence = id_valid & id_fence_i & ~ex_redirect & ~pipe_freeze:
  - IDLE with ex_valid|mem_valid: go to DRAIN, ifid_stall=pc_stall=idex_bubble=1.
  - IDLE with both shadows empty: fence_i_pulse=1 this cycle, no stall.
  - DRAIN with both shadows empty and no freeze: fence_i_pulse=1, release stall, go to IDLE.
  - DRAIN otherwise: keep the stall.
  - ex_redirect during DRAIN: abort to IDLE with no pulse; the fence was on the wrong path.
- Output priority, highest first:
  1. pipe_freeze: overrides everything; all other strobes are 0 and the redirect is not acted on. EX holds ex_redirect until unfrozen.
  2. ex_redirect: ifid_flush=1, idex_bubble=1, no stall, lu ignored.
  3. Fence drain stall.
  4. lu: pc_stall=ifid_stall=idex_bubble=1 for exactly one cycle per hazard under FWD_EN=1.
- stall_cycles: increments on each edge where pc_stall=1 (freeze also sets pc_stall=1). Saturates at all-ones and never wraps.
- Simultaneous lu with fence: handled as the drain stall only.
- rst asserted mid-DRAIN or mid-MEM_WAIT: returns to the reset state immediately, with no pulses.

Test Plan:
- Load-use stall: EX holds `ld x5`, ID issues `add x6,x5,x1` -> one cycle of pc_stall=ifid_stall=idex_bubble=1; add issues next cycle; stall_cycles=1.
- x0 and forwarding: load rd=x0 then use x0 -> no stall. With FWD_EN=0, `addi x7` in MEM and ID reads x7 -> one stall cycle.
- Slow memory: mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_freeze=1 for 3 cycles, shadows unchanged, stall_cycles +3.
- Memory timeout: MEM_TIMEOUT=4, mem_ready stuck at 0 -> pipe_freeze on cycles 0-3, mem_timeout=1 on cycle 4 only, FSM back in RUN.
- Redirect priority: ex_redirect coincides with a load-use match -> ifid_flush=1, idex_bubble=1, pc_stall=0; the EX shadow is empty next cycle.
- fence.i drain: load in EX, ALU op in MEM, fence.i in ID -> stalled for 2 cycles, fence_i_pulse on cycle 3.
  - Repeat with ex_redirect on cycle 1 -> no pulse.
  - Repeat with rst on cycle 1 -> everything returns to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall / flush controller for a 5-stage RV64 pipeline
// (IF, ID, EX, MEM, WB).
//
// The block keeps a two-entry shadow scoreboard of the destinations in flight
// in EX and MEM. It uses that scoreboard to detect RAW hazards against the
// instruction in ID. A memory-wait FSM freezes the whole pipe while the data
// memory is slow and forces a release after MEM_TIMEOUT frozen cycles. A
// fence.i FSM drains EX/MEM before it requests an I-cache invalidate.
//
// Parameters
//   FWD_EN      : 1 = EX/MEM bypass exists, so only load-use stalls;
//                 0 = any RAW hit against EX or MEM stalls.
//   MEM_TIMEOUT : maximum number of frozen cycles for one access (>= 2).
//   CNT_W       : width of the stall performance counter.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   id_valid                 : ID holds a valid instruction
//   id_rs1_ena/id_rs1_addr   : ID reads rs1 / rs1 index
//   id_rs2_ena/id_rs2_addr   : ID reads rs2 / rs2 index
//   id_rd_ena/id_rd_addr     : ID writes rd / rd index
//   id_mem_to_reg            : ID instruction is a load
//   id_fence_i               : ID instruction is fence.i
//   ex_redirect              : EX resolved a taken control transfer
//   mem_req, mem_ready       : MEM data-access handshake
//   pc_stall, ifid_stall     : hold PC / hold IF/ID
//   ifid_flush               : clear IF/ID to a NOP
//   idex_bubble              : load a NOP into ID/EX
//   pipe_freeze              : hold every pipeline register
//   fence_i_pulse            : one-cycle I-cache invalidate request
//   mem_timeout              : one-cycle forced completion (error) for MEM
//   stall_cycles             : saturating count of cycles with pc_stall=1
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs1_ena,
  input  logic [4:0]       id_rs1_addr,
  input  logic             id_rs2_ena,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rd_ena,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_mem_to_reg,
  input  logic             id_fence_i,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             fence_i_pulse,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  // The wait counter must be able to hold MEM_TIMEOUT itself.
  localparam int                WCNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  SCNT_ONE   = CNT_W'(1);

  typedef enum logic {
    MEM_RUN  = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic {
    FEN_IDLE  = 1'b0,
    FEN_DRAIN = 1'b1
  } fen_state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  mem_state_e        mem_state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  fen_state_e        fen_state_q;

  // Shadow scoreboard. Index 0 is the EX stage and index 1 is the MEM stage.
  // Only EX needs the load flag. Once a load reaches MEM, its data is either
  // bypassed (FWD_EN=1) or the hit stalls anyway (FWD_EN=0).
  logic [1:0]      sh_valid_q, sh_valid_d;
  logic [1:0][4:0] sh_rd_q, sh_rd_d;
  logic            ex_ld_q, ex_ld_d;

  logic [CNT_W-1:0] stall_cnt_q;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  logic [1:0] stage_hit;
  logic       lu_fwd;
  logic       lu_nofwd;
  logic       lu;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      // x0 is never a real dependency.
      assign stage_hit[gi] = sh_valid_q[gi] & (sh_rd_q[gi] != 5'd0) &
                             ((id_rs1_ena & (id_rs1_addr == sh_rd_q[gi])) |
                              (id_rs2_ena & (id_rs2_addr == sh_rd_q[gi])));
    end
  endgenerate

  assign lu_fwd   = id_valid & stage_hit[0] & ex_ld_q;
  assign lu_nofwd = id_valid & (|stage_hit);
  assign lu       = (FWD_EN != 0) ? lu_fwd : lu_nofwd;

  // -------------------------------------------------------------------------
  // Memory wait: freeze / timeout decode
  // -------------------------------------------------------------------------
  logic freeze_w;
  logic timeout_w;

  always_comb begin
    freeze_w  = 1'b0;
    timeout_w = 1'b0;
    if (!rst) begin
      case (mem_state_q)
        // The first slow cycle freezes without waiting for a register. It is
        // frozen cycle number 1 of at most MEM_TIMEOUT.
        MEM_RUN: freeze_w = mem_req & ~mem_ready;
        MEM_WAIT: begin
          freeze_w  = ~mem_ready & (wait_cnt_q != WCNT_LIMIT);
          timeout_w = ~mem_ready & (wait_cnt_q == WCNT_LIMIT);
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // fence.i decode
  // -------------------------------------------------------------------------
  logic busy;
  logic fence_req;
  logic draining;
  logic drain_stall;
  logic fence_fire;

  assign busy      = |sh_valid_q;
  assign fence_req = id_valid & id_fence_i & ~ex_redirect & ~freeze_w;
  assign draining  = (fen_state_q == FEN_DRAIN);

  // Stall while anything older is still in flight, whether the drain starts
  // this cycle or is already under way. Redirect and freeze take priority
  // over this stall in the output mux below.
  assign drain_stall = busy & (draining | fence_req);

  // Fire the invalidate once the pipe is empty. A redirect during a drain
  // means the fence was on the wrong path, so it must not fire.
  assign fence_fire  = ~busy & ~freeze_w & ~ex_redirect & (draining | fence_req);

  // -------------------------------------------------------------------------
  // Output strobes, in priority order
  // -------------------------------------------------------------------------
  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    pipe_freeze   = 1'b0;
    fence_i_pulse = 1'b0;
    mem_timeout   = 1'b0;
    if (!rst) begin
      mem_timeout   = timeout_w;
      fence_i_pulse = fence_fire;
      if (freeze_w) begin
        // pc_stall also marks freeze cycles so the counter includes them.
        pipe_freeze = 1'b1;
        pc_stall    = 1'b1;
      end else if (ex_redirect) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (drain_stall || lu) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shadow scoreboard next state
  // -------------------------------------------------------------------------
  logic issue;

  assign issue = id_valid & ~ifid_stall & ~ex_redirect;

  always_comb begin
    sh_valid_d = sh_valid_q;
    sh_rd_d    = sh_rd_q;
    ex_ld_d    = ex_ld_q;
    if (!freeze_w) begin
      sh_valid_d[1] = sh_valid_q[0];
      sh_rd_d[1]    = sh_rd_q[0];
      sh_valid_d[0] = issue;
      sh_rd_d[0]    = (issue & id_rd_ena) ? id_rd_addr : 5'd0;
      ex_ld_d       = issue & id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_valid_q <= '0;
      sh_rd_q    <= '0;
      ex_ld_q    <= 1'b0;
    end else begin
      sh_valid_q <= sh_valid_d;
      sh_rd_q    <= sh_rd_d;
      ex_ld_q    <= ex_ld_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory-wait FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_state_q <= MEM_RUN;
      wait_cnt_q  <= '0;
    end else begin
      case (mem_state_q)
        MEM_RUN: begin
          if (mem_req && !mem_ready) begin
            mem_state_q <= MEM_WAIT;
            wait_cnt_q  <= WCNT_ONE;
          end
        end
        MEM_WAIT: begin
          if (mem_ready || (wait_cnt_q == WCNT_LIMIT)) begin
            mem_state_q <= MEM_RUN;
            wait_cnt_q  <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCNT_ONE;
          end
        end
        default: begin
          mem_state_q <= MEM_RUN;
          wait_cnt_q  <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // fence.i drain FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fen_state_q <= FEN_IDLE;
    end else begin
      case (fen_state_q)
        FEN_IDLE: begin
          if (fence_req && busy) begin
            fen_state_q <= FEN_DRAIN;
          end
        end
        FEN_DRAIN: begin
          // Leave the drain state on completion or on a wrong-path abort.
          // While frozen, keep draining.
          if (!freeze_w && (ex_redirect || !busy)) begin
            fen_state_q <= FEN_IDLE;
          end
        end
        default: fen_state_q <= FEN_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stall performance counter (saturating)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pc_stall && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + SCNT_ONE;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for pipe_hazard_ctrl. Two instances share every input:
//   u0 : FWD_EN=1, MEM_TIMEOUT=4, CNT_W=64
//   u1 : FWD_EN=0, MEM_TIMEOUT=4, CNT_W=4   (the counter saturates quickly)
// Each cycle, a reference model predicts the outputs of both instances. The
// model tracks in-flight instructions, a frozen-cycle tally, and a "fence
// waiting" flag. Directed scenarios come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_ena, id_rs2_ena, id_rd_ena, id_mem_to_reg, id_fence_i;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       ex_redirect, mem_req, mem_ready;

  logic        a_pc, a_ifs, a_fl, a_bb, a_frz, a_fen, a_tmo;
  logic [63:0] a_cnt;
  logic        b_pc, b_ifs, b_fl, b_bb, b_frz, b_fen, b_tmo;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(T), .CNT_W(64)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_ena(id_rs1_ena), .id_rs1_addr(id_rs1_addr),
    .id_rs2_ena(id_rs2_ena), .id_rs2_addr(id_rs2_addr),
    .id_rd_ena(id_rd_ena), .id_rd_addr(id_rd_addr),
    .id_mem_to_reg(id_mem_to_reg), .id_fence_i(id_fence_i),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(a_pc), .ifid_stall(a_ifs), .ifid_flush(a_fl), .idex_bubble(a_bb),
    .pipe_freeze(a_frz), .fence_i_pulse(a_fen), .mem_timeout(a_tmo),
    .stall_cycles(a_cnt));

  pipe_hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(T), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_ena(id_rs1_ena), .id_rs1_addr(id_rs1_addr),
    .id_rs2_ena(id_rs2_ena), .id_rs2_addr(id_rs2_addr),
    .id_rd_ena(id_rd_ena), .id_rd_addr(id_rd_addr),
    .id_mem_to_reg(id_mem_to_reg), .id_fence_i(id_fence_i),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(b_pc), .ifid_stall(b_ifs), .ifid_flush(b_fl), .idex_bubble(b_bb),
    .pipe_freeze(b_frz), .fence_i_pulse(b_fen), .mem_timeout(b_tmo),
    .stall_cycles(b_cnt));

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  slot_t           m_ex [2];
  slot_t           m_mem[2];
  bit              m_fence_wait[2];
  longint unsigned m_stalls[2];
  int              m_waited;          // frozen cycles spent on the current access

  // Expected strobes: {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fence_i_pulse, mem_timeout}
  logic [6:0] e_str[2];
  bit         e_issue[2];
  bit         e_fence_next[2];
  bit         e_freeze;

  function automatic bit uses_reg(input logic [4:0] r);
    return (r != 5'd0) && ((id_rs1_ena && id_rs1_addr == r) || (id_rs2_ena && id_rs2_addr == r));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_fence_wait[k] = 0; m_stalls[k] = 0;
    end
    m_waited = 0;
  endtask

  task automatic model_eval();
    bit tmo, busy, hazard, freq, pc, ifs, fl, bb, pulse, fw;
    if (m_waited == 0) e_freeze = mem_req && !mem_ready;
    else               e_freeze = !mem_ready && (m_waited < T);
    tmo = (m_waited == T) && !mem_ready;
    for (int k = 0; k < 2; k++) begin
      busy = m_ex[k].v || m_mem[k].v;
      if (k == 0) hazard = id_valid && m_ex[k].v && m_ex[k].ld && uses_reg(m_ex[k].rd);
      else        hazard = id_valid && ((m_ex[k].v && uses_reg(m_ex[k].rd)) ||
                                        (m_mem[k].v && uses_reg(m_mem[k].rd)));
      freq = id_valid && id_fence_i && !ex_redirect && !e_freeze;
      {pc, ifs, fl, bb, pulse} = '0;
      fw = m_fence_wait[k];
      if (e_freeze) pc = 1;
      else if (ex_redirect) begin fl = 1; bb = 1; fw = 0; end
      else if (m_fence_wait[k]) begin
        if (busy) {pc, ifs, bb} = 3'b111; else begin pulse = 1; fw = 0; end
      end else if (freq) begin
        if (busy) begin {pc, ifs, bb} = 3'b111; fw = 1; end else pulse = 1;
      end else if (hazard) {pc, ifs, bb} = 3'b111;
      e_str[k]        = rst ? 7'd0 : {pc, ifs, fl, bb, e_freeze, pulse, tmo};
      e_issue[k]      = id_valid && !ifs && !ex_redirect;
      e_fence_next[k] = fw;
    end
  endtask

  task automatic model_step();
    longint unsigned maxc;
    if (rst) begin model_reset(); return; end
    for (int k = 0; k < 2; k++) begin
      maxc = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd15;
      m_fence_wait[k] = e_fence_next[k];
      if (!e_freeze) begin
        m_mem[k] = m_ex[k];
        m_ex[k]  = e_issue[k] ? {1'b1, (id_rd_ena ? id_rd_addr : 5'd0), id_mem_to_reg} : '0;
      end
      if (e_str[k][6] && m_stalls[k] != maxc) m_stalls[k]++;
    end
    m_waited = e_freeze ? m_waited + 1 : 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Waits until mid-cycle, then compares against the model.
  task automatic settle(input string tag);
    #4;
    if (rst) model_reset();
    model_eval();
    chk({tag, "/u0_strobes"}, {a_pc, a_ifs, a_fl, a_bb, a_frz, a_fen, a_tmo}, e_str[0]);
    chk({tag, "/u0_cnt"}, a_cnt, m_stalls[0]);
    chk({tag, "/u1_strobes"}, {b_pc, b_ifs, b_fl, b_bb, b_frz, b_fen, b_tmo}, e_str[1]);
    chk({tag, "/u1_cnt"}, 64'(b_cnt), m_stalls[1]);
    $display("%0t %s rst=%b v=%b rs=%b%0d/%b%0d rd=%b%0d ld=%b fi=%b redir=%b mreq=%b rdy=%b | u0=%b c0=%0d u1=%b c1=%0d",
             $time, tag, rst, id_valid, id_rs1_ena, id_rs1_addr, id_rs2_ena, id_rs2_addr,
             id_rd_ena, id_rd_addr, id_mem_to_reg, id_fence_i, ex_redirect, mem_req, mem_ready,
             {a_pc, a_ifs, a_fl, a_bb, a_frz, a_fen, a_tmo}, a_cnt,
             {b_pc, b_ifs, b_fl, b_bb, b_frz, b_fen, b_tmo}, b_cnt);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_id(input logic v, input logic r1e, input logic [4:0] r1,
                        input logic r2e, input logic [4:0] r2, input logic rde,
                        input logic [4:0] rd, input logic ld, input logic fi);
    id_valid = v; id_rs1_ena = r1e; id_rs1_addr = r1; id_rs2_ena = r2e; id_rs2_addr = r2;
    id_rd_ena = rde; id_rd_addr = rd; id_mem_to_reg = ld; id_fence_i = fi;
  endtask

  task automatic idle_in();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1; idle_in();
    settle(tag);
    chk({tag, "/u0_zero"}, {a_pc, a_ifs, a_fl, a_bb, a_frz, a_fen, a_tmo}, 7'd0);
    chk({tag, "/u0_cnt_zero"}, a_cnt, 64'd0);
    advance();
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; idle_in(); model_reset();
    @(posedge clk); #1;
    do_reset("reset");

    // Load-use: ld x5 then add x6,x5,x1
    set_id(1, 1, 1, 0, 0, 1, 5, 1, 0); settle("lu ld"); advance();
    set_id(1, 1, 5, 1, 1, 1, 6, 0, 0); settle("lu add1");
    chk("lu stall", {a_pc, a_ifs, a_bb}, 3'b111);
    advance();
    settle("lu add2");
    chk("lu release", a_pc, 1'b0);
    chk("lu count", a_cnt, 64'd1);
    advance();

    // x0 never stalls; FWD_EN=0 stalls on ALU result in MEM
    do_reset("rst x0");
    set_id(1, 1, 1, 0, 0, 1, 0, 1, 0); settle("x0 ld"); advance();
    set_id(1, 1, 0, 1, 0, 1, 3, 0, 0); settle("x0 use");
    chk("x0 u0", a_pc, 1'b0); chk("x0 u1", b_pc, 1'b0);
    advance();
    set_id(1, 1, 1, 0, 0, 1, 7, 0, 0); settle("addi x7"); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("gap"); advance();
    set_id(1, 1, 7, 0, 0, 1, 8, 0, 0); settle("use x7");
    chk("mem raw u1", b_pc, 1'b1); chk("mem raw u0", a_pc, 1'b0);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("after x7");
    chk("mem raw cnt", b_cnt, 4'd1);
    advance();

    // Slow memory: three not-ready cycles, then ready
    do_reset("rst slow");
    set_id(1, 1, 1, 0, 0, 1, 5, 1, 0); settle("slow ld"); advance();
    set_id(1, 1, 5, 1, 1, 1, 6, 0, 0); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle("slow wait");
      chk("slow freeze", {a_pc, a_ifs, a_fl, a_bb, a_frz}, 5'b10001);
      advance();
    end
    mem_ready = 1; settle("slow done");
    chk("slow unfrozen lu", {a_frz, a_pc, a_ifs}, 3'b011);
    chk("slow count", a_cnt, 64'd3);
    advance();

    // Memory timeout with ready stuck low
    do_reset("rst tmo");
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < T; i++) begin
      settle("tmo wait");
      chk("tmo freeze", {a_frz, a_tmo}, 2'b10);
      advance();
    end
    settle("tmo fire");
    chk("tmo pulse", {a_frz, a_tmo}, 2'b01);
    advance();
    mem_req = 0; settle("tmo after");
    chk("tmo run", {a_frz, a_tmo}, 2'b00);
    advance();

    // Redirect beats load-use
    do_reset("rst redir");
    set_id(1, 1, 1, 0, 0, 1, 5, 1, 0); settle("redir ld"); advance();
    set_id(1, 1, 5, 1, 1, 1, 6, 0, 0); ex_redirect = 1; settle("redir hit");
    chk("redir prio", {a_pc, a_fl, a_bb}, 3'b011);
    advance();
    ex_redirect = 0; settle("redir after");
    chk("redir ex empty", a_pc, 1'b0);
    advance();

    // fence.i drain: three variants (clean, redirect abort, reset abort)
    for (int v = 0; v < 3; v++) begin
      do_reset("rst fence");
      set_id(1, 1, 2, 0, 0, 1, 9, 0, 0); settle("fence alu"); advance();
      set_id(1, 1, 2, 0, 0, 1, 5, 1, 0); settle("fence ld"); advance();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); settle("fence c1");
      chk("fence c1 stall", {a_pc, a_ifs, a_bb, a_fen}, 4'b1110);
      advance();
      if (v == 1) ex_redirect = 1;
      if (v == 2) rst = 1;
      settle("fence c2");
      if (v == 0) chk("fence c2 stall", {a_pc, a_ifs, a_bb, a_fen}, 4'b1110);
      if (v == 1) chk("fence c2 redir", {a_pc, a_fl, a_bb, a_fen}, 4'b0110);
      if (v == 2) chk("fence c2 rst", {a_pc, a_ifs, a_fl, a_bb, a_frz, a_fen, a_tmo, a_cnt}, 71'd0);
      advance();
      rst = 0; ex_redirect = 0;
      if (v != 0) set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle("fence c3");
      chk("fence c3 pulse", {a_pc, a_fen}, (v == 0) ? 2'b01 : 2'b00);
      advance();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("fence c4");
      chk("fence c4 quiet", a_fen, 1'b0);
      advance();
    end

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      set_id(($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      ex_redirect = ($urandom_range(0, 7) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = ($urandom_range(0, 2) == 0);
      settle("rand");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
